apb_modport: RTL and testbench
==============================

// Module: apb_modport
// PURPOSE
// - APB (v3-style) completer with a register-file memory: DEPTH words of DATA_WIDTH bits.
// - Zero wait states, with error response on an out-of-range address or a protocol violation.
// - Sits behind the apb_inf DRV_MP/MON_MP interface; it is the slave that the APB driver and monitor exercise.
// PARAMETERS
// - ADDR_WIDTH  4   PADDAR width in bits
// - DATA_WIDTH  8   PWDATA/PRDATA width in bits
// - DEPTH       16  number of memory words; valid addresses are 0..DEPTH-1
// PORTS
// - PCLK     in   1           clock; all state changes on the rising edge
// - RESETn   in   1           reset; asynchronous, active-low
// - PSLEx    in   1           slave select
// - PENABLE  in   1           access-phase strobe
// - PWRITE   in   1           1 = write, 0 = read
// - PADDAR   in   ADDR_WIDTH  word address
// - PWDATA   in   DATA_WIDTH  write data
// - PRDATA   out  DATA_WIDTH  read data
// - PREADY   out  1           transfer complete
// - PSLVERR  out  1           error response, qualified by PREADY
// BEHAVIOUR
// - Reset (RESETn=0, async): memory cleared to 0; PRDATA=0, PREADY=0, PSLVERR=0; FSM enters IDLE.
// - FSM tracks the bus phase:
//   - IDLE: PSLEx=0.
//   - SETUP: first cycle with PSLEx=1 and PENABLE=0.
//   - ACCESS: PSLEx=1 and PENABLE=1.
// - FSM transitions:
//   - IDLE -> SETUP on PSLEx & !PENABLE.
//   - SETUP -> ACCESS always; the next cycle must have PENABLE=1.
//   - ACCESS -> SETUP if PSLEx & !PENABLE (back-to-back transfer).
//   - ACCESS -> IDLE if !PSLEx.
// - PREADY is combinational: PREADY = PSLEx & PENABLE. It is 0 in SETUP and 1 in every ACCESS cycle, so every transfer is exactly 2 cycles.
// - Write: on the ACCESS edge (PSLEx & PENABLE & PWRITE) with a valid address, mem[PADDAR] <= PWDATA.
// - Read:
//   - In SETUP with PWRITE=0, PRDATA <= mem[PADDAR] (valid address) or 0 (invalid address).
//   - PRDATA is therefore stable through ACCESS and holds its value until the next read.
// - Read of a word written in the immediately preceding transfer returns the new data; the write completes before the following SETUP.
// - PSLVERR (combinational, asserted only while PREADY=1) is raised when either:
//   - PADDAR >= DEPTH (only reachable when 2**ADDR_WIDTH > DEPTH), or
//   - PENABLE=1 arrives without a preceding SETUP (FSM in IDLE, or ACCESS repeated without an intervening SETUP).
// - PSLVERR = 0 on every valid access.
// - An erroring transfer never writes memory; an erroring read drives PRDATA=0.
// - PENABLE=1 with PSLEx=0: ignored; FSM stays in or returns to IDLE.
// - RESETn asserted mid-transfer: the transfer is aborted, no memory write occurs, outputs take reset values immediately.
// - Address/data changes between SETUP and ACCESS are not checked. Write address and data are taken from the ACCESS cycle.
// STRUCTURE
// - Package apb_pkg holds:
//   - constants ADDR_WIDTH, DATA_WIDTH, DEPTH;
//   - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
//   - typedefs addr_t and data_t.
// - Sub-module apb_modport_mem: DEPTH x DATA_WIDTH register file.
//   - Asynchronous read port; write port with write enable.
//   - Async active-low clear.
// - Top level holds the phase FSM, PREADY/PSLVERR logic and the PRDATA register.
// TESTING
// - Reset: assert RESETn=0 mid-write, then release; read addr 3 -> PRDATA=8'h00, PSLVERR=0, and PREADY=0 during every SETUP.
// - Write then read: write 8'hA5 to addr 4, then read addr 4 -> PRDATA=8'hA5 during ACCESS, PREADY=1, PSLVERR=0; each transfer is 2 cycles.
// - Full sweep: write addr i with 8'h10+i for i=0..15, then read back -> each returns 8'h10+i. Addr 15 (boundary) is OK.
// - Back-to-back: write addr 7 = 8'h3C, and go ACCESS -> SETUP directly into a read of addr 7 -> PRDATA=8'h3C, with no IDLE cycle needed.
// - Protocol error: PSLEx=1 and PENABLE=1 from IDLE with PWRITE=1, addr 2 -> PREADY=1, PSLVERR=1, mem[2] unchanged.
// - Out of range: with ADDR_WIDTH=5, write addr 20 -> PSLVERR=1, no write; read addr 20 -> PRDATA=0, PSLVERR=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared constants and types for the APB register-file completer.
// Default geometry: 16 words of 8 bits behind a 4-bit word address.
// The phase encoding is shared by the top-level FSM and anything that observes it.
package apb_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/apb_modport_mem.sv
// DEPTH x DATA_WIDTH register file: one write port, one asynchronous read port.
// Write lands on the rising edge when we=1; the read port follows raddr with no delay.
// No flow control; the async active-low clear zeroes every word.
module apb_modport_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  import apb_pkg::*;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage: clear everything on reset, otherwise take the write when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_modport.sv
// APB completer in front of a register file; every transfer is SETUP + one ACCESS cycle.
// PREADY is high in every ACCESS cycle (zero wait states); read data is registered during SETUP.
// No backpressure: the completer never stalls. Out-of-range or phase-violating accesses get PSLVERR.
module apb_modport #(
  parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
  parameter int DEPTH      = apb_pkg::DEPTH
) (
  input  logic                  PCLK,
  input  logic                  RESETn,
  input  logic                  PSLEx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDAR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);
  import apb_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e            state;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  addr_ok;
  logic                  setup_cyc;
  logic                  access_cyc;
  logic                  proto_err;
  logic                  err;
  logic                  mem_we;

  // One extra bit on the compare so DEPTH == 2**ADDR_WIDTH does not wrap to zero.
  assign addr_ok    = ({1'b0, PADDAR} < (ADDR_WIDTH+1)'(DEPTH));
  assign setup_cyc  = PSLEx & ~PENABLE;
  // Reset gates the access strobe so outputs drop the moment RESETn falls.
  assign access_cyc = RESETn & PSLEx & PENABLE;
  // An access is legal only when the previous cycle was a SETUP.
  assign proto_err  = (state != SETUP);
  assign err        = access_cyc & (~addr_ok | proto_err);
  assign mem_we     = access_cyc & PWRITE & ~err;

  assign PREADY  = access_cyc;
  assign PSLVERR = err;
  // A failing read returns zero even if the register still holds an earlier read.
  assign PRDATA  = (err & ~PWRITE) ? '0 : prdata_q;

  // Bus-phase tracker: the state names the phase of the previous cycle.
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (setup_cyc) state <= SETUP;
        end
        SETUP: begin
          state <= ACCESS;
        end
        ACCESS: begin
          if (!PSLEx)         state <= IDLE;
          else if (!PENABLE)  state <= SETUP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read data is captured in SETUP so it is stable for the whole ACCESS cycle.
  always_ff @(posedge PCLK or negedge RESETn) begin
    if (!RESETn) begin
      prdata_q <= '0;
    end else if (setup_cyc && !PWRITE) begin
      prdata_q <= addr_ok ? mem_rdata : '0;
    end
  end

  apb_modport_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (RESETn),
    .we    (mem_we),
    .waddr (PADDAR[IDX_W-1:0]),
    .wdata (PWDATA),
    .raddr (PADDAR[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Directed and randomized APB transfers against two completers (4-bit and 5-bit address).
// Expected data comes from a word-array model updated per completed transfer.
// Bus inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_apb_modport;

  logic       PCLK = 1'b0;
  logic       RESETn;

  logic       a_sel, a_en, a_wr;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       a_rdy, a_err;

  logic       b_sel, b_en, b_wr;
  logic [4:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       b_rdy, b_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ma [16];
  logic [7:0] mb [16];

  always #5 PCLK = ~PCLK;

  apb_modport dut (
    .PCLK(PCLK), .RESETn(RESETn), .PSLEx(a_sel), .PENABLE(a_en), .PWRITE(a_wr),
    .PADDAR(a_addr), .PWDATA(a_wdata), .PRDATA(a_rdata), .PREADY(a_rdy), .PSLVERR(a_err)
  );

  apb_modport #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(16)) dut5 (
    .PCLK(PCLK), .RESETn(RESETn), .PSLEx(b_sel), .PENABLE(b_en), .PWRITE(b_wr),
    .PADDAR(b_addr), .PWDATA(b_wdata), .PRDATA(b_rdata), .PREADY(b_rdy), .PSLVERR(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_set(input bit b, input bit sel, input bit en, input bit wr,
                         input logic [4:0] addr, input logic [7:0] d);
    if (!b) begin
      a_sel = sel; a_en = en; a_wr = wr; a_addr = addr[3:0]; a_wdata = d;
    end else begin
      b_sel = sel; b_en = en; b_wr = wr; b_addr = addr; b_wdata = d;
    end
  endtask

  task automatic idle(input bit b);
    @(posedge PCLK); #1;
    bus_set(b, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
  endtask

  // One complete SETUP+ACCESS transfer, checked against the word model.
  task automatic do_op(input bit b, input bit wr, input logic [4:0] addr,
                       input logic [7:0] d, input string tag);
    logic       rdy_s, err_s, rdy_a, err_a;
    logic [7:0] rd, exp_rd;
    bit         bad;
    @(posedge PCLK); #1;
    bus_set(b, 1'b1, 1'b0, wr, addr, d);
    @(negedge PCLK);
    rdy_s = b ? b_rdy : a_rdy;
    err_s = b ? b_err : a_err;
    @(posedge PCLK); #1;
    bus_set(b, 1'b1, 1'b1, wr, addr, d);
    @(negedge PCLK);
    rdy_a = b ? b_rdy : a_rdy;
    err_a = b ? b_err : a_err;
    rd    = b ? b_rdata : a_rdata;
    bad   = (addr >= 5'd16);
    check({tag, " setup_pready"}, rdy_s, 0);
    check({tag, " setup_pslverr"}, err_s, 0);
    check({tag, " access_pready"}, rdy_a, 1);
    check({tag, " access_pslverr"}, err_a, bad);
    if (!wr) begin
      exp_rd = bad ? 8'h00 : (b ? mb[addr[3:0]] : ma[addr[3:0]]);
      check({tag, " prdata"}, rd, exp_rd);
    end else if (!bad) begin
      if (b) mb[addr[3:0]] = d;
      else   ma[addr[3:0]] = d;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] ra;
    logic [7:0] rdat;
    bit         rwr;

    RESETn = 1'b0;
    bus_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    bus_set(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    clear_models();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset prdata", a_rdata, 0);
    check("reset pready", a_rdy, 0);
    check("reset pslverr", a_err, 0);
    RESETn = 1'b1;

    // Simple write then read.
    do_op(1'b0, 1'b1, 5'd4, 8'hA5, "wr4");
    idle(1'b0);
    do_op(1'b0, 1'b0, 5'd4, 8'h00, "rd4");
    idle(1'b0);

    // Full sweep, back-to-back writes then back-to-back reads.
    for (int i = 0; i < 16; i++) do_op(1'b0, 1'b1, 5'(i), 8'(8'h10 + i), $sformatf("sweep_wr%0d", i));
    for (int i = 0; i < 16; i++) do_op(1'b0, 1'b0, 5'(i), 8'h00, $sformatf("sweep_rd%0d", i));
    idle(1'b0);

    // Write directly followed by a read of the same word, no idle between.
    do_op(1'b0, 1'b1, 5'd7, 8'h3C, "b2b_wr7");
    do_op(1'b0, 1'b0, 5'd7, 8'h00, "b2b_rd7");
    idle(1'b0);

    // PENABLE straight from IDLE on a write.
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 8'hEE);
    @(negedge PCLK);
    check("proto_wr pready", a_rdy, 1);
    check("proto_wr pslverr", a_err, 1);
    idle(1'b0);
    do_op(1'b0, 1'b0, 5'd2, 8'h00, "proto_rd2");
    idle(1'b0);

    // PENABLE straight from IDLE on a read: data forced to zero.
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 8'h00);
    @(negedge PCLK);
    check("proto_rd pready", a_rdy, 1);
    check("proto_rd pslverr", a_err, 1);
    check("proto_rd prdata", a_rdata, 0);
    idle(1'b0);

    // A second ACCESS cycle without a new SETUP must not write.
    do_op(1'b0, 1'b1, 5'd9, 8'h11, "rep_wr9");
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 8'h22);
    @(negedge PCLK);
    check("rep_access pslverr", a_err, 1);
    idle(1'b0);
    do_op(1'b0, 1'b0, 5'd9, 8'h00, "rep_rd9");
    idle(1'b0);

    // Reset asserted in the ACCESS cycle of a write.
    do_op(1'b0, 1'b1, 5'd3, 8'h55, "pre_rst_wr3");
    idle(1'b0);
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 8'h77);
    @(posedge PCLK); #1;
    bus_set(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 8'h77);
    #2 RESETn = 1'b0;
    #1;
    check("midrst pready", a_rdy, 0);
    check("midrst pslverr", a_err, 0);
    check("midrst prdata", a_rdata, 0);
    clear_models();
    bus_set(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    @(negedge PCLK);
    RESETn = 1'b1;
    do_op(1'b0, 1'b0, 5'd3, 8'h00, "post_rst_rd3");
    do_op(1'b0, 1'b0, 5'd4, 8'h00, "post_rst_rd4");
    idle(1'b0);

    // Randomized transfers with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      rwr  = 1'($urandom_range(0, 1));
      ra   = 5'($urandom_range(0, 15));
      rdat = 8'($urandom);
      do_op(1'b0, rwr, ra, rdat, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle(1'b0);
    end
    idle(1'b0);

    // Wider address bus: out-of-range words never alias onto real ones.
    do_op(1'b1, 1'b1, 5'd4, 8'h99, "w5_wr4");
    do_op(1'b1, 1'b1, 5'd20, 8'h42, "w5_wr20");
    do_op(1'b1, 1'b0, 5'd20, 8'h00, "w5_rd20");
    do_op(1'b1, 1'b0, 5'd4, 8'h00, "w5_rd4");
    do_op(1'b1, 1'b0, 5'd15, 8'h00, "w5_rd15");
    for (int i = 0; i < 60; i++) begin
      rwr  = 1'($urandom_range(0, 1));
      ra   = 5'($urandom_range(0, 31));
      rdat = 8'($urandom);
      do_op(1'b1, rwr, ra, rdat, $sformatf("w5_rand%0d", i));
      if ($urandom_range(0, 2) == 0) idle(1'b1);
    end
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
